dl11_console: RTL
=================

// Module: dl11_console
// PURPOSE
//  DL11-style console serial line on the J11 I/O page (17777560-17777566). Sits directly downstream of
//  the unibus address decoder: consumes its uartreq/uartaddr/uartwr/uartwdata strobes, answers with
//  uartack/uartrdata, and drives a physical 8N1 UART (rxd/txd). Raises level receive/transmit IRQs.
// PARAMETERS
//  CLKDIV   434   clk cycles per serial bit (50 MHz / 115200); must be >= 4
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-high reset
//  uartreq    in   1   one-cycle access strobe from decoder
//  uartaddr   in   3   byte offset in register window; [2:1] selects reg, [0] ignored
//  uartwr     in   1   1 = write, 0 = read; valid with uartreq
//  uartwdata  in   16  write data; valid with uartreq
//  uartack    out  1   one-cycle completion pulse
//  uartrdata  out  16  read data; valid in the uartack cycle
//  rxd        in   1   serial input, asynchronous, idle high
//  txd        out  1   serial output, idle high
//  rxirq      out  1   RCSR.IE & RCSR.DONE
//  txirq      out  1   XCSR.IE & XCSR.READY
// BEHAVIOUR
//  Reset: uartack=0, uartrdata=0, txd=1, all IE=0, DONE=0, READY=1, OR=FE=0, RX/TX FSMs IDLE;
//   an in-flight frame is abandoned (txd returns high immediately).
//  Bus: uartack asserted exactly 1 cycle after uartreq, for 1 cycle, reads and writes alike.
//   uartreq never arrives while uartack is pending; a second strobe is not queued.
//  Registers (addr[2:1]); unlisted bits read 0, writes to them ignored:
//   0 RCSR: [7] DONE ro, [6] IE rw
//   1 RBUF: [15] ERR=OR|FE, [14] OR, [13] FE, [7:0] data; ro. Read returns
//       current value then clears DONE, OR, FE (data retained)
//   2 XCSR: [7] READY ro, [6] IE rw
//   3 XBUF: [7:0] wo (reads 0); write loads holding reg, READY<=0;
//       write while READY=0 overwrites holding reg (no error)
//  Rx input: rxd passed through 2-flop synchroniser before any use.
//  RX FSM IDLE->START->DATA->STOP->IDLE:
//   IDLE: on sync rxd=0 load bit counter CLKDIV/2 -> START.
//   START: at count expiry re-sample; 1 = glitch -> IDLE, 0 -> DATA (counter reload CLKDIV).
//   DATA: sample 8 bits LSB first at CLKDIV intervals -> STOP.
//   STOP: sample at CLKDIV; store byte to RBUF, FE<=~sample, OR<=DONE, DONE<=1 -> IDLE
//     (a low stop bit still completes; next start search begins after rxd goes high).
//  Simultaneous RBUF read and byte completion: completion wins; new data stored, DONE=1,
//   OR=0 (old byte counted as consumed), FE from new frame; read returns pre-update value.
//  TX: holding reg + shift reg. TX FSM IDLE->START->DATA->STOP->IDLE, each bit CLKDIV clk.
//   IDLE with READY=0: move holding->shift, READY<=1 same cycle, txd<=0 next cycle.
//   STOP: txd=1 for CLKDIV cycles; back-to-back frames have exactly one stop bit.
//   XBUF write coinciding with holding->shift transfer: transfer takes old byte,
//   new byte lands in holding, READY ends 0.
//  rxirq/txirq: combinational from registered bits, no extra latency.
// TESTING
//  T1 reset: rst pulse mid TX frame -> txd=1 same cycle, XCSR read = 0x0080, RCSR read = 0x0000.
//  T2 TX: write XBUF 0x41 -> READY drops then rises 1 cycle later; txd shows 0,1,0,0,0,0,0,1,0,1
//     each CLKDIV wide; second write 0x42 right away -> gapless frame following stop bit.
//  T3 RX: drive 0x5A 8N1 on rxd -> DONE=1, rxirq=1 only if RCSR.IE=1; RBUF read = 0x005A,
//     following RCSR read = 0x0000 (with IE=0).
//  T4 overrun/framing: two frames without RBUF read, second with low stop bit -> RBUF = 0xE000|byte2;
//     next RBUF read shows ERR/OR/FE cleared.
//  T5 glitch: rxd low for CLKDIV/4 only -> no DONE, RX FSM back to IDLE.
//  T6 bus timing: every read/write at offsets 0..7 -> uartack exactly 1 cycle after uartreq;
//     addr[0]=1 aliases even register; XBUF read = 0x0000.

Source files
------------

// File: rtl/dl11_console.sv
// dl11_console: DL11-style console serial line for the J11 I/O page window
// 17777560-17777566. It answers one-cycle strobes from the unibus address
// decoder with a one-cycle ack, and drives an 8N1 UART.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   uartreq/uartwr      access strobe and direction (1 = write)
//   uartaddr[2:0]       byte offset; [2:1] selects RCSR/RBUF/XCSR/XBUF
//   uartwdata[15:0]     write data
//   uartack             completion pulse, one cycle after uartreq
//   uartrdata[15:0]     read data, valid with uartack (0 otherwise)
//   rxd / txd           serial in (asynchronous, idle high) / serial out
//   rxirq / txirq       level interrupts: RCSR.IE&DONE, XCSR.IE&READY
//
// RX states
//   state     | meaning
//   RX_IDLE   | waiting for a falling edge on synchronised rxd
//   RX_START  | half-bit wait, then re-check start bit (glitch filter)
//   RX_DATA   | sampling 8 data bits LSB first, one per CLKDIV
//   RX_STOP   | sampling stop bit, then storing the byte into RBUF
// TX states
//   state     | meaning
//   TX_IDLE   | line high, waiting for READY=0
//   TX_START  | start bit (low) for CLKDIV cycles
//   TX_DATA   | 8 data bits LSB first
//   TX_STOP   | stop bit (high); chains directly into next frame
module dl11_console #(
    parameter int CLKDIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uartreq,
    input  logic [2:0]  uartaddr,
    input  logic        uartwr,
    input  logic [15:0] uartwdata,
    output logic        uartack,
    output logic [15:0] uartrdata,
    input  logic        rxd,
    output logic        txd,
    output logic        rxirq,
    output logic        txirq
);

    localparam int CW = $clog2(CLKDIV);
    localparam logic [CW-1:0] FULL = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKDIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // bus side
    logic        uartack_q, uartack_d;
    logic [15:0] uartrdata_q, uartrdata_d;
    // registers
    logic        rx_done_q, rx_done_d, rx_ie_q, rx_ie_d;
    logic        rx_or_q, rx_or_d, rx_fe_q, rx_fe_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        tx_ready_q, tx_ready_d, tx_ie_q, tx_ie_d;
    logic [7:0]  tx_hold_q, tx_hold_d;
    // receiver
    logic        rxd_meta_q, rxd_meta_d, rxd_sync_q, rxd_sync_d;
    rx_state_t   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_wait_hi_q, rx_wait_hi_d;
    // transmitter
    tx_state_t   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d;

    logic        rd_req, wr_req, rbuf_rd, xbuf_wr, tx_load;
    logic [1:0]  sel;
    logic [15:0] rd_mux;
    logic        unused_bits;

    assign unused_bits = ^{uartaddr[0], uartwdata[15:7], uartwdata[5:0]};

    assign sel     = uartaddr[2:1];
    assign rd_req  = uartreq & ~uartwr;
    assign wr_req  = uartreq & uartwr;
    assign rbuf_rd = rd_req & (sel == 2'd1);
    assign xbuf_wr = wr_req & (sel == 2'd3);

    always_comb begin
        rd_mux = 16'h0000;
        case (sel)
            2'd0: rd_mux = {8'h00, rx_done_q, rx_ie_q, 6'h00};
            2'd1: rd_mux = {rx_or_q | rx_fe_q, rx_or_q, rx_fe_q, 5'h00, rx_data_q};
            2'd2: rd_mux = {8'h00, tx_ready_q, tx_ie_q, 6'h00};
            default: rd_mux = 16'h0000;
        endcase
    end

    always_comb begin
        uartack_d    = uartreq;
        uartrdata_d  = rd_req ? rd_mux : 16'h0000;
        rx_done_d    = rx_done_q;
        rx_ie_d      = rx_ie_q;
        rx_or_d      = rx_or_q;
        rx_fe_d      = rx_fe_q;
        rx_data_d    = rx_data_q;
        tx_ready_d   = tx_ready_q;
        tx_ie_d      = tx_ie_q;
        tx_hold_d    = tx_hold_q;
        rxd_meta_d   = rxd;
        rxd_sync_d   = rxd_meta_q;
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_wait_hi_d = rx_wait_hi_q & ~rxd_sync_q;
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        txd_d        = txd_q;
        tx_load      = 1'b0;

        if (wr_req && sel == 2'd0) rx_ie_d = uartwdata[6];
        if (wr_req && sel == 2'd2) tx_ie_d = uartwdata[6];

        if (rbuf_rd) begin
            rx_done_d = 1'b0;
            rx_or_d   = 1'b0;
            rx_fe_d   = 1'b0;
        end

        case (rx_state_q)
            RX_IDLE: begin
                // after a low stop bit, wait for the line to go high before
                // hunting for the next start bit
                if (!rxd_sync_q && !rx_wait_hi_q) begin
                    rx_cnt_d   = HALF;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (rxd_sync_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_cnt_d   = FULL;
                        rx_bit_d   = 3'd0;
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = FULL;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: begin
                if (rx_cnt_q == '0) begin
                    // completion beats a coincident RBUF read; that read
                    // consumed the old byte so it is not an overrun
                    rx_data_d    = rx_shift_q;
                    rx_fe_d      = ~rxd_sync_q;
                    rx_or_d      = rx_done_q & ~rbuf_rd;
                    rx_done_d    = 1'b1;
                    rx_wait_hi_d = ~rxd_sync_q;
                    rx_state_d   = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
        endcase

        case (tx_state_q)
            TX_IDLE: begin
                if (!tx_ready_q) tx_load = 1'b1;
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    txd_d      = tx_shift_q[0];
                    tx_cnt_d   = FULL;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = FULL;
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        txd_d      = tx_shift_q[1];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            default: begin
                if (tx_cnt_q == '0) begin
                    // chain straight into the next start bit so back-to-back
                    // frames carry exactly one stop bit
                    if (!tx_ready_q) tx_load    = 1'b1;
                    else             tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
        endcase

        if (tx_load) begin
            tx_shift_d = tx_hold_q;
            tx_ready_d = 1'b1;
            txd_d      = 1'b0;
            tx_cnt_d   = FULL;
            tx_state_d = TX_START;
        end

        // a write coinciding with the transfer lands after it, leaving READY=0
        if (xbuf_wr) begin
            tx_hold_d  = uartwdata[7:0];
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uartack_q    <= 1'b0;
            uartrdata_q  <= 16'h0000;
            rx_done_q    <= 1'b0;
            rx_ie_q      <= 1'b0;
            rx_or_q      <= 1'b0;
            rx_fe_q      <= 1'b0;
            rx_data_q    <= 8'h00;
            tx_ready_q   <= 1'b1;
            tx_ie_q      <= 1'b0;
            tx_hold_q    <= 8'h00;
            rxd_meta_q   <= 1'b1;
            rxd_sync_q   <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'h00;
            rx_wait_hi_q <= 1'b0;
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= 3'd0;
            tx_shift_q   <= 8'h00;
            txd_q        <= 1'b1;
        end else begin
            uartack_q    <= uartack_d;
            uartrdata_q  <= uartrdata_d;
            rx_done_q    <= rx_done_d;
            rx_ie_q      <= rx_ie_d;
            rx_or_q      <= rx_or_d;
            rx_fe_q      <= rx_fe_d;
            rx_data_q    <= rx_data_d;
            tx_ready_q   <= tx_ready_d;
            tx_ie_q      <= tx_ie_d;
            tx_hold_q    <= tx_hold_d;
            rxd_meta_q   <= rxd_meta_d;
            rxd_sync_q   <= rxd_sync_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_wait_hi_q <= rx_wait_hi_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            txd_q        <= txd_d;
        end
    end

    assign uartack   = uartack_q;
    assign uartrdata = uartrdata_q;
    assign txd       = txd_q;
    assign rxirq     = rx_ie_q & rx_done_q;
    assign txirq     = tx_ie_q & tx_ready_q;

endmodule
